// File: rtl/ahb_mreq_pkg.sv
// Shared types and constants for the AHB-Lite master requester.
package ahb_mreq_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } mreq_state_e;

  localparam int unsigned BOUNDARY_BYTES = 1024;
  localparam int unsigned BOUNDARY_LSB   = $clog2(BOUNDARY_BYTES);

endpackage

// File: rtl/ahb_mreq_addr_gen.sv
// Next-beat address for an INCR burst; a beat that crosses a 1 KB boundary restarts as NONSEQ.
import ahb_mreq_pkg::*;

module ahb_mreq_addr_gen #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output htrans_e           next_trans_o,
  output logic              cross_o
);

  logic [ADDR_W-1:0] incr;

  always_comb begin
    incr         = {{(ADDR_W-1){1'b0}}, 1'b1} << size_i;
    next_addr_o  = addr_i + incr;
    cross_o      = next_addr_o[ADDR_W-1:BOUNDARY_LSB] != addr_i[ADDR_W-1:BOUNDARY_LSB];
    next_trans_o = cross_o ? HT_NONSEQ : HT_SEQ;
  end

endmodule

// File: rtl/ahb_master_req.sv
// AHB-Lite master requester: turns one local burst command into a pipelined INCR transaction.
// Optional grant-wait timeout enabled by defining AHB_MREQ_TIMEOUT_EN.
import ahb_mreq_pkg::*;

module ahb_master_req #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              done_err,
  output logic              hreq,
  output logic              hlast,
  input  logic              hgrant,
  input  logic              hwait,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp
);

  if (TIMEOUT_CYC == 0 || DATA_W < 8 || ADDR_W <= BOUNDARY_LSB) begin : g_bad_cfg
    $error("ahb_master_req: unsupported parameter combination");
  end

  mreq_state_e       state_q;
  htrans_e           htrans_q;
  logic              cmd_ready_q;
  logic              hreq_q;
  logic              hlast_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [2:0]        hburst_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              dp_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              done_err_q;

  logic [ADDR_W-1:0] next_addr;
  htrans_e           next_trans;
  logic              next_cross;
  logic              dp_done;
  logic              err_now;
  logic              acc;
  logic              tmo_hit;

  ahb_mreq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr_i       (haddr_q),
    .size_i       (hsize_q),
    .next_addr_o  (next_addr),
    .next_trans_o (next_trans),
    .cross_o      (next_cross)
  );

  // hgrant is pre-masked by ~hwait, so an accepted address also completes any pending data phase.
  assign dp_done = dp_q && !hwait;
  assign err_now = dp_done && hresp;
  assign acc     = (state_q == ST_ADDR) && (htrans_q != HT_IDLE) && hgrant && !err_now;

`ifdef AHB_MREQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_wait;

  assign tmo_wait = (state_q == ST_REQ) || ((state_q == ST_ADDR) && (htrans_q == HT_IDLE));
  assign tmo_hit  = tmo_wait && !hgrant && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_wait || hgrant || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HT_IDLE;
      cmd_ready_q <= 1'b0;
      hreq_q      <= 1'b0;
      hlast_q     <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hburst_q    <= HBURST_SINGLE;
      hwdata_q    <= '0;
      cnt_q       <= '0;
      dp_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;

      if (dp_done) dp_q <= 1'b0;
      if (acc)     dp_q <= 1'b1;
      if (acc && hwrite_q) hwdata_q <= wr_data;
      if (dp_done && !hresp && !hwrite_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= hrdata;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            haddr_q     <= cmd_addr;
            hwrite_q    <= cmd_write;
            hsize_q     <= cmd_size;
            hburst_q    <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
            cnt_q       <= cmd_len;
            hlast_q     <= (cmd_len == '0);
            hreq_q      <= 1'b1;
            state_q     <= ST_REQ;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_REQ: begin
          if (hgrant) begin
            htrans_q <= HT_NONSEQ;
            state_q  <= ST_ADDR;
          end else if (tmo_hit) begin
            hreq_q      <= 1'b0;
            hlast_q     <= 1'b0;
            done_q      <= 1'b1;
            done_err_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        ST_ADDR: begin
          if (err_now) begin
            htrans_q <= HT_IDLE;
            hreq_q   <= 1'b0;
            hlast_q  <= 1'b0;
            dp_q     <= 1'b0;
            state_q  <= ST_ERR;
          end else if (acc) begin
            if (cnt_q == '0) begin
              htrans_q <= HT_IDLE;
              hreq_q   <= 1'b0;
              state_q  <= ST_DATA;
            end else begin
              haddr_q  <= next_addr;
              htrans_q <= next_trans;
              cnt_q    <= cnt_q - 1'b1;
              hlast_q  <= (cnt_q == LEN_W'(1));
            end
          end else if (htrans_q == HT_IDLE) begin
            // Preempted: the held beat restarts as NONSEQ once grant returns.
            if (hgrant) begin
              htrans_q <= HT_NONSEQ;
            end else if (tmo_hit) begin
              hreq_q      <= 1'b0;
              hlast_q     <= 1'b0;
              dp_q        <= 1'b0;
              done_q      <= 1'b1;
              done_err_q  <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end else if (!hwait) begin
            htrans_q <= HT_IDLE;
          end
        end

        ST_DATA: begin
          if (err_now) begin
            hlast_q <= 1'b0;
            state_q <= ST_ERR;
          end else if (dp_done) begin
            hlast_q     <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        ST_ERR: begin
          done_q      <= 1'b1;
          done_err_q  <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = acc && hwrite_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign hreq      = hreq_q;
  assign hlast     = hlast_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = hburst_q;
  assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_req.sv
// Directed bench for ahb_master_req; exercises the timeout path when AHB_MREQ_TIMEOUT_EN is defined.
module tb_ahb_master_req;

  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        done_err;
  logic        hreq;
  logic        hlast;
  logic        hgrant = 1'b0;
  logic        hwait = 1'b0;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hresp = 1'b0;

  always #5 hclk = ~hclk;

  ahb_master_req #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .LEN_W       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_size  (cmd_size),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .done_err  (done_err),
    .hreq      (hreq),
    .hlast     (hlast),
    .hgrant    (hgrant),
    .hwait     (hwait),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hresp     (hresp)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] log_addr[$];
  logic [1:0]  log_trans[$];
  logic        log_last[$];
  logic [31:0] rd_log[$];
  int unsigned wr_cnt   = 0;
  int unsigned done_cnt = 0;
  logic        last_err = 1'b0;

  // Bus-side observer: accepted addresses, read beats, write handshakes, completions.
  always @(posedge hclk) begin
    if (hreset_n) begin
      if (htrans != 2'd0 && hgrant && !(hresp && !hwait)) begin
        log_addr.push_back(haddr);
        log_trans.push_back(htrans);
        log_last.push_back(hlast);
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if (wr_ready) wr_cnt++;
      if (done) begin
        done_cnt++;
        last_err = done_err;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic g, input logic w, input logic r, input logic [31:0] d);
    hgrant = g;
    hwait  = w;
    hresp  = r;
    hrdata = d;
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [3:0] len);
    int unsigned n = 0;
    while (!cmd_ready && n < 20) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    check_eq("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_addr  = a;
    cmd_write = wr;
    cmd_size  = sz;
    cmd_len   = len;
    cmd_valid = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_done(input string t, input int unsigned max);
    int unsigned n = 0;
    logic seen = 1'b0;
    while (!seen && n < max) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      seen = done;
      n++;
    end
    check_eq({t, "_done_seen"}, {31'b0, seen}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_beats(input string t, input int unsigned base, input int unsigned n,
                             input logic [31:0] ea[4], input logic [1:0] et[4], input logic el[4]);
    check_eq({t, "_nbeats"}, 32'(log_addr.size()) - base, n);
    for (int unsigned i = 0; i < n; i++) begin
      if (base + i < 32'(log_addr.size())) begin
        check_eq($sformatf("%s_addr%0d", t, i), log_addr[base+i], ea[i]);
        check_eq($sformatf("%s_trans%0d", t, i), {30'b0, log_trans[base+i]}, {30'b0, et[i]});
        check_eq($sformatf("%s_last%0d", t, i), {31'b0, log_last[base+i]}, {31'b0, el[i]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ba, br, bw, bd;

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    check_eq("rst_hreq", {31'b0, hreq}, 32'd0);
    check_eq("rst_htrans", {30'b0, htrans}, 32'd0);
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_hlast", {31'b0, hlast}, 32'd0);
    hreset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // T1: 4-beat read at 0x100, word size
    ba = log_addr.size(); br = rd_log.size(); bd = done_cnt;
    issue(32'h100, 1'b0, 3'd2, 4'd3);
    check_eq("t1_req_hreq", {31'b0, hreq}, 32'd1);
    check_eq("t1_req_htrans", {30'b0, htrans}, 32'd0);
    check_eq("t1_hburst", {29'b0, hburst}, 32'd1);
    check_eq("t1_hsize", {29'b0, hsize}, 32'd2);
    tick(1'b0, 1'b0, 1'b0, 32'hEE);
    tick(1'b1, 1'b0, 1'b0, 32'hEE);
    check_eq("t1_nonseq", {30'b0, htrans}, 32'd2);
    tick(1'b1, 1'b0, 1'b0, 32'hEE);
    tick(1'b1, 1'b0, 1'b0, 32'h11);
    tick(1'b1, 1'b0, 1'b0, 32'h22);
    tick(1'b1, 1'b0, 1'b0, 32'h33);
    check_eq("t1_post_hreq", {31'b0, hreq}, 32'd0);
    check_eq("t1_post_hlast", {31'b0, hlast}, 32'd1);
    check_eq("t1_post_htrans", {30'b0, htrans}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h44);
    check_eq("t1_done", {31'b0, done}, 32'd1);
    check_eq("t1_done_err", {31'b0, done_err}, 32'd0);
    check_eq("t1_hlast_clr", {31'b0, hlast}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_beats("t1", ba, 4, '{32'h100, 32'h104, 32'h108, 32'h10C},
                '{2'd2, 2'd3, 2'd3, 2'd3}, '{1'b0, 1'b0, 1'b0, 1'b1});
    check_eq("t1_nrd", 32'(rd_log.size()) - br, 32'd4);
    if (rd_log.size() >= br + 4) begin
      check_eq("t1_rd0", rd_log[br], 32'h11);
      check_eq("t1_rd1", rd_log[br+1], 32'h22);
      check_eq("t1_rd2", rd_log[br+2], 32'h33);
      check_eq("t1_rd3", rd_log[br+3], 32'h44);
    end
    check_eq("t1_ndone", done_cnt - bd, 32'd1);

    // T2: 2-beat write, beat 0 data phase stalled 2 cycles
    ba = log_addr.size(); bw = wr_cnt; bd = done_cnt;
    issue(32'h100, 1'b1, 3'd2, 4'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    wr_data = 32'hA1A1_0001;
    tick(1'b1, 1'b0, 1'b0, '0);
    check_eq("t2_hwdata0", hwdata, 32'hA1A1_0001);
    wr_data = 32'h5555_5555;
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    check_eq("t2_hold_addr", haddr, 32'h104);
    check_eq("t2_hold_trans", {30'b0, htrans}, 32'd3);
    check_eq("t2_nwr_stall", wr_cnt - bw, 32'd1);
    wr_data = 32'hB2B2_0002;
    tick(1'b1, 1'b0, 1'b0, '0);
    check_eq("t2_hwdata1", hwdata, 32'hB2B2_0002);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t2_done", {31'b0, done}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_beats("t2", ba, 2, '{32'h100, 32'h104, 32'h0, 32'h0},
                '{2'd2, 2'd3, 2'd0, 2'd0}, '{1'b0, 1'b1, 1'b0, 1'b0});
    check_eq("t2_nwr", wr_cnt - bw, 32'd2);
    check_eq("t2_ndone", done_cnt - bd, 32'd1);

    // T3: burst across 1 KB boundary
    ba = log_addr.size();
    issue(32'h3F8, 1'b0, 3'd2, 4'd3);
    tick(1'b0, 1'b0, 1'b0, '0);
    run_to_done("t3", 30);
    check_beats("t3", ba, 4, '{32'h3F8, 32'h3FC, 32'h400, 32'h404},
                '{2'd2, 2'd3, 2'd2, 2'd3}, '{1'b0, 1'b0, 1'b0, 1'b1});

    // T4: grant preempted mid-burst, resumes as NONSEQ at the held address
    ba = log_addr.size(); br = rd_log.size();
    issue(32'h200, 1'b0, 3'd2, 4'd3);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t4_pre_htrans", {30'b0, htrans}, 32'd0);
    check_eq("t4_pre_hreq", {31'b0, hreq}, 32'd1);
    check_eq("t4_pre_haddr", haddr, 32'h208);
    tick(1'b1, 1'b0, 1'b0, '0);
    check_eq("t4_resume_trans", {30'b0, htrans}, 32'd2);
    check_eq("t4_resume_addr", haddr, 32'h208);
    run_to_done("t4", 30);
    check_beats("t4", ba, 4, '{32'h200, 32'h204, 32'h208, 32'h20C},
                '{2'd2, 2'd3, 2'd2, 2'd3}, '{1'b0, 1'b0, 1'b0, 1'b1});
    check_eq("t4_nrd", 32'(rd_log.size()) - br, 32'd4);

    // T5: ERROR response on beat 1 of a 4-beat read
    br = rd_log.size(); bd = done_cnt;
    issue(32'h300, 1'b0, 3'd2, 4'd3);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 32'h77);
    tick(1'b1, 1'b0, 1'b1, 32'h88);
    check_eq("t5_err_htrans", {30'b0, htrans}, 32'd0);
    check_eq("t5_err_hreq", {31'b0, hreq}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t5_done", {31'b0, done}, 32'd1);
    check_eq("t5_done_err", {31'b0, done_err}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t5_nrd", 32'(rd_log.size()) - br, 32'd1);
    check_eq("t5_ndone", done_cnt - bd, 32'd1);

    // T6: single-beat write
    ba = log_addr.size(); bw = wr_cnt;
    issue(32'h40, 1'b1, 3'd0, 4'd0);
    check_eq("t6_hburst", {29'b0, hburst}, 32'd0);
    check_eq("t6_hlast_req", {31'b0, hlast}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    run_to_done("t6", 20);
    check_beats("t6", ba, 1, '{32'h40, 32'h0, 32'h0, 32'h0},
                '{2'd2, 2'd0, 2'd0, 2'd0}, '{1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("t6_nwr", wr_cnt - bw, 32'd1);
    check_eq("t6_err", {31'b0, last_err}, 32'd0);

`ifdef AHB_MREQ_TIMEOUT_EN
    // T7: grant never arrives
    bd = done_cnt;
    issue(32'h600, 1'b0, 3'd2, 4'd1);
    repeat (7) tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t7_hreq_hold", {31'b0, hreq}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t7_hreq_drop", {31'b0, hreq}, 32'd0);
    check_eq("t7_done", {31'b0, done}, 32'd1);
    check_eq("t7_done_err", {31'b0, done_err}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t7_ndone", done_cnt - bd, 32'd1);
`endif

    // T8: reset mid-burst aborts without a done pulse
    bd = done_cnt;
    issue(32'h500, 1'b0, 3'd2, 4'd3);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    hreset_n = 1'b0;
    #1;
    check_eq("t8_rst_htrans", {30'b0, htrans}, 32'd0);
    check_eq("t8_rst_hreq", {31'b0, hreq}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, '0);
    hreset_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0);
    check_eq("t8_no_done", done_cnt - bd, 32'd0);
    check_eq("t8_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
